// File: rtl/muladd_result_collector.sv
// Result collector for the mul-add core: buffers one job's y results in a FWFT FIFO,
// streams them out with m_last on the final stored beat, and tracks sum/overflow/status.
module muladd_result_collector #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  job_len,
    input  logic [DATA_W-1:0] y_in,
    input  logic              y_valid_in,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [DATA_W-1:0] result_sum,
    output logic [1:0]        fsm_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_CNT  = (PTR_W + 1)'(1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  in_cnt;
    logic [CNT_W-1:0]  in_cnt_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              full;
    logic              pop;
    logic              take;
    logic              push;

    // Output handshake: a beat transfers on any posedge where m_valid && m_ready;
    // m_valid never drops and m_data never changes while a beat waits for m_ready.
    assign full       = (count == FULL_CNT);
    assign m_valid    = (count != '0);
    assign pop        = m_valid & m_ready;
    assign take       = (state == S_COLLECT) & y_valid_in;
    // A full FIFO still accepts a result when the head leaves in the same cycle.
    assign push       = take & (~full | pop);
    assign in_cnt_nxt = in_cnt + CNT_W'(1);

    assign m_data    = m_valid ? mem[rd_ptr] : '0;
    assign m_last    = m_valid & (in_cnt == len_q) & (count == ONE_CNT);
    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= y_in;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            len_q      <= '0;
            in_cnt     <= '0;
            result_sum <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q      <= job_len;
                        in_cnt     <= '0;
                        result_sum <= '0;
                        overflow   <= 1'b0;
                        if (job_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (take) begin
                        in_cnt <= in_cnt_nxt;
                        if (push) begin
                            result_sum <= result_sum + y_in;
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (in_cnt_nxt == len_q) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (count == '0) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
